// File: rtl/fetch_pkg.sv
// Shared types and constants for the matrix-datapath fetch sequencer.
package fetch_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDR_WIDTH    = 32;
  localparam int DEF_NUM_ROWS      = 9;
  localparam int DEF_BYTES_PER_ROW = 8;
  localparam int WORD_W            = DEF_DATA_WIDTH * DEF_BYTES_PER_ROW;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    UNPACK,
    DONE
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_word_unpacker.sv
// Holds one fetched memory word and walks through it byte by byte,
// least-significant byte first.
module word_unpacker
  import fetch_pkg::*;
#(
  parameter int  DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int  BYTES_PER_ROW = DEF_BYTES_PER_ROW,
  localparam int WORD_BITS     = DATA_WIDTH * BYTES_PER_ROW,
  localparam int IDX_W         = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WORD_BITS-1:0]  load_word,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] byte_data,
  output logic                  last
);

  logic [WORD_BITS-1:0] word_q;
  logic [IDX_W-1:0]     byte_idx_q;

  // Capture a new word on load, otherwise step to the next byte on each accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      byte_idx_q <= '0;
    end else if (clear) begin
      byte_idx_q <= '0;
    end else if (load) begin
      word_q     <= load_word;
      byte_idx_q <= '0;
    end else if (advance) begin
      if (last) begin
        byte_idx_q <= '0;
      end else begin
        byte_idx_q <= byte_idx_q + 1'b1;
      end
    end
  end

  // Present the currently selected byte and flag the final byte of the word.
  always_comb begin
    byte_data = word_q[byte_idx_q * DATA_WIDTH +: DATA_WIDTH];
    last      = (byte_idx_q == IDX_W'(BYTES_PER_ROW - 1));
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetches NUM_ROWS consecutive words over Avalon-MM starting at a sampled base
// address, then streams each word byte-wise into the matching per-row FIFO.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int  DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int  ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int  NUM_ROWS      = DEF_NUM_ROWS,
  parameter int  BYTES_PER_ROW = DEF_BYTES_PER_ROW,
  localparam int WORD_BITS     = DATA_WIDTH * BYTES_PER_ROW,
  localparam int ROW_W         = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  input  logic [WORD_BITS-1:0]  mem_readdata,
  input  logic                  mem_readdatavalid,
  input  logic                  mem_waitrequest,
  output logic [NUM_ROWS-1:0]   fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic [NUM_ROWS-1:0]   fifo_full
);

  fetch_state_e          state_q;
  logic [ROW_W-1:0]      row_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] next_row_addr;
  logic                  busy_q;
  logic                  done_q;
  logic                  mem_read_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;

  logic                  unpack_clear;
  logic                  unpack_load;
  logic                  write_ok;
  logic                  byte_last;
  logic                  last_row;
  logic [DATA_WIDTH-1:0] cur_byte;

  word_unpacker #(
    .DATA_WIDTH    (DATA_WIDTH),
    .BYTES_PER_ROW (BYTES_PER_ROW)
  ) u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (unpack_clear),
    .load      (unpack_load),
    .load_word (mem_readdata),
    .advance   (write_ok),
    .byte_data (cur_byte),
    .last      (byte_last)
  );

  // Decode the unpacker controls, the address of the following row and the FIFO write strobes.
  always_comb begin
    unpack_clear  = (state_q == IDLE) && start;
    unpack_load   = (state_q == WAIT_DATA) && mem_readdatavalid;
    write_ok      = (state_q == UNPACK) && !fifo_full[row_q];
    last_row      = (row_q == ROW_W'(NUM_ROWS - 1));
    next_row_addr = base_q + ADDR_WIDTH'(row_q) + ADDR_WIDTH'(1);
    fifo_wr_en    = '0;
    fifo_wr_data  = '0;
    if (write_ok) begin
      fifo_wr_en = NUM_ROWS'(1) << row_q;
    end
    if (state_q == UNPACK) begin
      fifo_wr_data = cur_byte;
    end
  end

  // Sequence control: request one word at a time, drain it into the FIFO, repeat per row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      row_q         <= '0;
      base_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q        <= base_addr;
            row_q         <= '0;
            mem_read_q    <= 1'b1;
            mem_address_q <= base_addr;
            busy_q        <= 1'b1;
            state_q       <= REQ;
          end
        end
        REQ: begin
          if (!mem_waitrequest) begin
            mem_read_q <= 1'b0;
            state_q    <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (mem_readdatavalid) begin
            state_q <= UNPACK;
          end
        end
        UNPACK: begin
          if (write_ok && byte_last) begin
            if (last_row) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              row_q         <= row_q + 1'b1;
              mem_address_q <= next_row_addr;
              mem_read_q    <= 1'b1;
              state_q       <= REQ;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Drive the registered handshake and status outputs.
  always_comb begin
    busy        = busy_q;
    done        = done_q;
    mem_read    = mem_read_q;
    mem_address = mem_address_q;
  end

  // Read data is only expected while a read is outstanding.
  a_rdv_only_waiting : assert property (@(posedge clk) disable iff (!rst_n)
    mem_readdatavalid |-> (state_q == WAIT_DATA));

  // A stalled request must stay asserted with an unchanged address.
  a_req_held : assert property (@(posedge clk) disable iff (!rst_n)
    (mem_read && mem_waitrequest) |=> (mem_read && $stable(mem_address)));

  // At most one FIFO is written per cycle and never a full one.
  a_wr_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(fifo_wr_en));

  a_no_wr_full : assert property (@(posedge clk) disable iff (!rst_n)
    ((fifo_wr_en & fifo_full) == '0));

endmodule
